keypad_scanner: RTL and testbench

- Scans a 4x4 hex keypad matrix by driving one column low at a time, reading the active-low row lines, debouncing whole-matrix frames and emitting one hex key code per press.
- Input-side counterpart to the multiplexed 7-segment display driver; uses the same 1110/1101/1011/0111 scan pattern on the column strobes.
- KeyHistory (last four codes) feeds the display driver's 16-bit input directly.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_debounce.sv | 45 ++++
 rtl/keypad_scanner.sv | 106 ++++++++++
 tb/tb_keypad_scanner.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key map, column strobes and priority helper for the keypad scanner.
package keypad_pkg;

    typedef enum logic {IDLE, HELD} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } lowest_t;

    // Indexed by matrix bit k = row*4 + col.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    localparam logic [3:0] COL_STROBE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic lowest_t lowest_set(input logic [15:0] v);
        lowest_t r;
        r = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) r = '{found: 1'b1, idx: 4'(i)};
        return r;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a frame into the debounced matrix once it repeats DEBOUNCE_SCANS times in a row.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] frame,
    input  logic        frame_end,
    output logic [15:0] matrix,
    output logic        update
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [15:0]   prev_q, prev_d, matrix_q, matrix_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          update_q, update_d;

    always_comb begin
        update_d = frame_end && frame == prev_q && cnt_q == CW'(DEBOUNCE_SCANS - 1);
        prev_d   = frame_end ? frame : prev_q;
        cnt_d    = !frame_end ? cnt_q :
                   frame != prev_q ? '0 :
                   cnt_q == CW'(DEBOUNCE_SCANS) ? cnt_q : cnt_q + 1'b1;
        matrix_d = update_d ? frame : matrix_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            matrix_q <= '0;
            update_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            matrix_q <= matrix_d;
            update_q <= update_d;
        end
    end

    assign matrix = matrix_q;
    assign update = update_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed 4x4 keypad scan with frame debounce and single-event press reporting.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 16000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic        KeyDown,
    output logic [15:0] KeyHistory
);

    localparam int TW = $clog2(SCAN_TICKS);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   frame_q, frame_d;
    logic          tick_end, frame_end;
    logic [15:0]   matrix;
    logic          update;
    state_t        state_q, state_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;
    logic [15:0]   history_q, history_d;
    lowest_t       pick;

    always_comb begin
        tick_end  = tick_q == TW'(SCAN_TICKS - 1);
        frame_end = tick_end && col_idx_q == 2'd3;
        tick_d    = tick_end ? '0 : tick_q + 1'b1;
        col_idx_d = col_idx_q + 2'(tick_end);
        frame_d   = frame_q;
        // Scatter the column's rows into row-major matrix positions.
        if (tick_end)
            for (int r = 0; r < 4; r++)
                frame_d[{2'(r), col_idx_q}] = ~row_sync_q[r];
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .CLK       (CLK),
        .Reset     (Reset),
        .frame     (frame_d),
        .frame_end (frame_end),
        .matrix    (matrix),
        .update    (update)
    );

    always_comb begin
        pick        = lowest_set(matrix);
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        history_d   = history_q;
        if (update && state_q == IDLE && pick.found) begin
            state_d     = HELD;
            key_code_d  = KEY_MAP[pick.idx];
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            history_d   = {history_q[11:0], KEY_MAP[pick.idx]};
        end else if (update && state_q == HELD && !pick.found) begin
            state_d    = IDLE;
            key_down_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            tick_q      <= '0;
            col_idx_q   <= '0;
            frame_q     <= '0;
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            history_q   <= '0;
        end else begin
            row_meta_q  <= Row;
            row_sync_q  <= row_meta_q;
            tick_q      <= tick_d;
            col_idx_q   <= col_idx_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            history_q   <= history_d;
        end
    end

    assign Col        = COL_STROBE[col_idx_q];
    assign KeyCode    = key_code_q;
    assign KeyValid   = key_valid_q;
    assign KeyDown    = key_down_q;
    assign KeyHistory = history_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed press/release vectors against a physical keypad model, plus bounce and reset sequences.
module tb_keypad_scanner;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic        KeyDown;
    logic [15:0] KeyHistory;
    logic [15:0] keys;

    int passed = 0;
    int total = 0;
    int pulses = 0;
    int doubles = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [3:0]  code;
        int          pulses;
        logic        down;
        logic [15:0] hist;
    } vec_t;

    vec_t tv [17];

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Row        (Row),
        .Col        (Col),
        .KeyCode    (KeyCode),
        .KeyValid   (KeyValid),
        .KeyDown    (KeyDown),
        .KeyHistory (KeyHistory)
    );

    always #5 CLK = ~CLK;

    // Pressed key at (r, c) pulls row r low while column c is strobed.
    always_comb begin
        Row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!Col[c] && keys[r*4+c]) Row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (KeyValid) pulses++;
            if (KeyValid && prev_valid) doubles++;
            prev_valid = KeyValid;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_col"}, 16'(Col), 16'hE);
        check({tag, "_code"}, 16'(KeyCode), 16'h0);
        check({tag, "_valid"}, 16'(KeyValid), 16'h0);
        check({tag, "_down"}, 16'(KeyDown), 16'h0);
        check({tag, "_hist"}, KeyHistory, 16'h0);
    endtask

    initial begin
        tv[0]  = '{16'h0040, 6, 4'h6, 1, 1'b1, 16'h0006};
        tv[1]  = '{16'h0000, 4, 4'h6, 0, 1'b0, 16'h0006};
        tv[2]  = '{16'h0001, 6, 4'h1, 1, 1'b1, 16'h0061};
        tv[3]  = '{16'h0000, 5, 4'h1, 0, 1'b0, 16'h0061};
        tv[4]  = '{16'h0002, 6, 4'h2, 1, 1'b1, 16'h0612};
        tv[5]  = '{16'h0000, 5, 4'h2, 0, 1'b0, 16'h0612};
        tv[6]  = '{16'h0004, 6, 4'h3, 1, 1'b1, 16'h6123};
        tv[7]  = '{16'h0000, 5, 4'h3, 0, 1'b0, 16'h6123};
        tv[8]  = '{16'h0008, 6, 4'hA, 1, 1'b1, 16'h123A};
        tv[9]  = '{16'h0000, 5, 4'hA, 0, 1'b0, 16'h123A};
        tv[10] = '{16'h2000, 6, 4'h0, 1, 1'b1, 16'h23A0};
        tv[11] = '{16'h0000, 5, 4'h0, 0, 1'b0, 16'h23A0};
        tv[12] = '{16'h8001, 6, 4'h1, 1, 1'b1, 16'h3A01};
        tv[13] = '{16'h8000, 5, 4'h1, 0, 1'b1, 16'h3A01};
        tv[14] = '{16'h0000, 5, 4'h1, 0, 1'b0, 16'h3A01};
        tv[15] = '{16'h8000, 6, 4'hD, 1, 1'b1, 16'hA01D};
        tv[16] = '{16'h0000, 5, 4'hD, 0, 1'b0, 16'hA01D};

        keys = '0;
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check_cleared("reset");
        Reset = 1'b0;
        for (int n = 0; n < 16; n++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            check($sformatf("col_seq%0d", n), 16'(Col), 16'(exp_col));
            @(negedge CLK);
        end
        pulses = 0;
        run(200);
        check("idle_pulses", 16'(pulses), 16'h0);
        check("idle_code", 16'(KeyCode), 16'h0);
        check("idle_down", 16'(KeyDown), 16'h0);
        check("idle_hist", KeyHistory, 16'h0);

        for (int i = 0; i < 17; i++) begin
            keys = tv[i].keys;
            pulses = 0;
            run(tv[i].frames * 16);
            check($sformatf("v%0d_pulses", i), 16'(pulses), 16'(tv[i].pulses));
            check($sformatf("v%0d_code", i), 16'(KeyCode), 16'(tv[i].code));
            check($sformatf("v%0d_down", i), 16'(KeyDown), 16'(tv[i].down));
            check($sformatf("v%0d_hist", i), KeyHistory, tv[i].hist);
        end

        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            run(16);
        end
        check("bounce_pulses", 16'(pulses), 16'h0);
        keys = 16'h0040;
        run(32);
        check("bounce_early", 16'(pulses), 16'h0);
        run(64);
        check("bounce_pulses_stable", 16'(pulses), 16'h1);
        check("bounce_code", 16'(KeyCode), 16'h6);
        check("bounce_hist", KeyHistory, 16'h01D6);
        keys = 16'h0000;
        run(80);
        check("bounce_release_down", 16'(KeyDown), 16'h0);

        keys = 16'h0040;
        pulses = 0;
        run(96);
        check("pre_reset_pulses", 16'(pulses), 16'h1);
        check("pre_reset_hist", KeyHistory, 16'h1D66);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check_cleared("mid_reset");
        pulses = 0;
        prev_valid = 1'b0;
        run(96);
        check("post_reset_pulses", 16'(pulses), 16'h1);
        check("post_reset_code", 16'(KeyCode), 16'h6);
        check("post_reset_down", 16'(KeyDown), 16'h1);
        check("post_reset_hist", KeyHistory, 16'h0006);

        check("no_double_valid", 16'(doubles), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
